// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared opcode encodings and saturation-limit helpers for the
//                pipelined ALU and its shift unit.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

    // Opcode encodings
    localparam logic [3:0] c_OP_ADD    = 4'b0000;
    localparam logic [3:0] c_OP_SUB    = 4'b0001;
    localparam logic [3:0] c_OP_XOR    = 4'b0010;
    localparam logic [3:0] c_OP_RED    = 4'b0011;
    localparam logic [3:0] c_OP_SLL    = 4'b0100;
    localparam logic [3:0] c_OP_SRA    = 4'b0101;
    localparam logic [3:0] c_OP_ROR    = 4'b0110;
    localparam logic [3:0] c_OP_PADDSB = 4'b0111;
    localparam logic [3:0] c_OP_LW     = 4'b1000;
    localparam logic [3:0] c_OP_SW     = 4'b1001;
    localparam logic [3:0] c_OP_LLB    = 4'b1010;
    localparam logic [3:0] c_OP_LHB    = 4'b1011;

    // Widest datapath the saturation helpers can describe
    localparam int c_MAX_W = 64;

    // Largest positive two's-complement value of a w-bit field (0111..1);
    // callers truncate the result to w bits.
    function automatic logic [c_MAX_W-1:0] sat_pos(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Most negative two's-complement value of a w-bit field (1000..0);
    // callers truncate the result to w bits.
    function automatic logic [c_MAX_W-1:0] sat_neg(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_shift_unit.sv
`default_nettype none
// ============================================================================
//  Module      : alu_shift_unit
//  Description : Purely combinational shift/rotate datapath: logical left
//                shift, arithmetic right shift and rotate right of i_a.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_shift_unit #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0]         i_a,
    input  logic [$clog2(WIDTH)-1:0] i_amt,
    output logic [WIDTH-1:0]         o_sll,
    output logic [WIDTH-1:0]         o_sra,
    output logic [WIDTH-1:0]         o_ror
);

    localparam int c_AW = $clog2(WIDTH);

    // Rotation is modulo WIDTH so non-power-of-two widths wrap correctly
    logic [c_AW-1:0] w_rot_amt;

    assign w_rot_amt = c_AW'(32'(i_amt) % WIDTH);
    assign o_sll     = i_a << i_amt;
    assign o_sra     = $signed(i_a) >>> i_amt;
    // Rotating right equals shifting a doubled copy and keeping the low half
    assign o_ror     = WIDTH'({i_a, i_a} >> w_rot_amt);

endmodule
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pipe
//  Description : Two-stage pipelined ALU with valid/ready handshakes on both
//                sides. Stage 1 captures operands; stage 2 holds the result
//                and the z/n/v flag state. Latency is two cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int LANE_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic [7:0]       imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             z,
    output logic             n,
    output logic             v
);

    localparam int c_AW    = $clog2(WIDTH);
    localparam int c_NLANE = WIDTH / LANE_W;
    localparam int c_NBYTE = WIDTH / 8;

    localparam logic [WIDTH-1:0]  c_SAT_POS  = WIDTH'(sat_pos(WIDTH));
    localparam logic [WIDTH-1:0]  c_SAT_NEG  = WIDTH'(sat_neg(WIDTH));
    localparam logic [LANE_W-1:0] c_LANE_POS = LANE_W'(sat_pos(LANE_W));
    localparam logic [LANE_W-1:0] c_LANE_NEG = LANE_W'(sat_neg(LANE_W));
    localparam logic [WIDTH-1:0]  c_BYTE0    = WIDTH'(8'hFF);

    // Stage 1: operand capture
    logic             r_s1_valid;
    logic [3:0]       r_s1_op;
    logic [WIDTH-1:0] r_s1_rs;
    logic [WIDTH-1:0] r_s1_rt;
    logic [7:0]       r_s1_imm;

    // Stage 2: result and flag state
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_z;
    logic             r_n;
    logic             r_v;

    // Handshake
    logic w_s2_free;
    logic w_s1_move;
    logic w_s1_load;

    // Datapath
    logic [WIDTH:0]   w_add_ext;
    logic [WIDTH:0]   w_sub_ext;
    logic             w_add_ovf;
    logic             w_sub_ovf;
    logic [WIDTH-1:0] w_add_sat;
    logic [WIDTH-1:0] w_sub_sat;
    logic [WIDTH-1:0] w_padd;
    logic [WIDTH-1:0] w_red;
    logic [WIDTH-1:0] w_sll;
    logic [WIDTH-1:0] w_sra;
    logic [WIDTH-1:0] w_ror;
    logic [WIDTH-1:0] w_res;
    logic             w_ovf;
    logic             w_upd_z;
    logic             w_upd_nv;

    // Stage 2 frees up when empty or when its result retires this cycle
    assign w_s2_free = !r_s2_valid || out_ready;
    assign w_s1_move = r_s1_valid && w_s2_free;
    assign in_ready  = !r_s1_valid || w_s2_free;
    assign w_s1_load = in_valid && in_ready;

    assign out_valid = r_s2_valid;
    assign result    = r_result;
    assign z         = r_z;
    assign n         = r_n;
    assign v         = r_v;

    // Full-width add/subtract with one guard bit for overflow detection
    assign w_add_ext = {r_s1_rs[WIDTH-1], r_s1_rs} + {r_s1_rt[WIDTH-1], r_s1_rt};
    assign w_sub_ext = {r_s1_rs[WIDTH-1], r_s1_rs} - {r_s1_rt[WIDTH-1], r_s1_rt};
    assign w_add_ovf = w_add_ext[WIDTH] ^ w_add_ext[WIDTH-1];
    assign w_sub_ovf = w_sub_ext[WIDTH] ^ w_sub_ext[WIDTH-1];
    // Guard bit carries the true sign, so it picks the clamp direction
    assign w_add_sat = w_add_ovf ? (w_add_ext[WIDTH] ? c_SAT_NEG : c_SAT_POS)
                                 : w_add_ext[WIDTH-1:0];
    assign w_sub_sat = w_sub_ovf ? (w_sub_ext[WIDTH] ? c_SAT_NEG : c_SAT_POS)
                                 : w_sub_ext[WIDTH-1:0];

    // Per-lane saturating signed add
    for (genvar k = 0; k < c_NLANE; k++) begin : g_lane
        logic [LANE_W:0] w_sum;
        logic            w_lovf;
        assign w_sum  = {r_s1_rs[k*LANE_W+LANE_W-1], r_s1_rs[k*LANE_W +: LANE_W]}
                      + {r_s1_rt[k*LANE_W+LANE_W-1], r_s1_rt[k*LANE_W +: LANE_W]};
        assign w_lovf = w_sum[LANE_W] ^ w_sum[LANE_W-1];
        assign w_padd[k*LANE_W +: LANE_W] =
            w_lovf ? (w_sum[LANE_W] ? c_LANE_NEG : c_LANE_POS) : w_sum[LANE_W-1:0];
    end

    // Byte reduction: the sum of 2*WIDTH/8 signed bytes always fits in WIDTH
    always_comb begin
        w_red = '0;
        for (int b = 0; b < c_NBYTE; b++) begin
            w_red = w_red
                  + {{(WIDTH-8){r_s1_rs[8*b+7]}}, r_s1_rs[8*b +: 8]}
                  + {{(WIDTH-8){r_s1_rt[8*b+7]}}, r_s1_rt[8*b +: 8]};
        end
    end

    alu_shift_unit #(
        .WIDTH (WIDTH)
    ) u_shift (
        .i_a   (r_s1_rs),
        .i_amt (r_s1_imm[c_AW-1:0]),
        .o_sll (w_sll),
        .o_sra (w_sra),
        .o_ror (w_ror)
    );

    // Result select and which flags this opcode is allowed to touch
    always_comb begin
        w_res    = '0;
        w_ovf    = 1'b0;
        w_upd_z  = 1'b0;
        w_upd_nv = 1'b0;
        case (r_s1_op)
            c_OP_ADD: begin
                w_res    = w_add_sat;
                w_ovf    = w_add_ovf;
                w_upd_z  = 1'b1;
                w_upd_nv = 1'b1;
            end
            c_OP_SUB: begin
                w_res    = w_sub_sat;
                w_ovf    = w_sub_ovf;
                w_upd_z  = 1'b1;
                w_upd_nv = 1'b1;
            end
            c_OP_XOR: begin
                w_res   = r_s1_rs ^ r_s1_rt;
                w_upd_z = 1'b1;
            end
            c_OP_RED:    w_res = w_red;
            c_OP_SLL: begin
                w_res   = w_sll;
                w_upd_z = 1'b1;
            end
            c_OP_SRA: begin
                w_res   = w_sra;
                w_upd_z = 1'b1;
            end
            c_OP_ROR: begin
                w_res   = w_ror;
                w_upd_z = 1'b1;
            end
            c_OP_PADDSB: w_res = w_padd;
            c_OP_LW,
            c_OP_SW:     w_res = w_add_ext[WIDTH-1:0];
            c_OP_LLB:    w_res = (r_s1_rs & ~c_BYTE0) | WIDTH'(r_s1_imm);
            c_OP_LHB:    w_res = (r_s1_rs & ~(c_BYTE0 << 8)) | (WIDTH'(r_s1_imm) << 8);
            default:     w_res = '0;
        endcase
    end

    // Stage 1 register: load on accept, otherwise drain into stage 2
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= '0;
            r_s1_rs    <= '0;
            r_s1_rt    <= '0;
            r_s1_imm   <= '0;
        end else if (w_s1_load) begin
            r_s1_valid <= 1'b1;
            r_s1_op    <= opcode;
            r_s1_rs    <= rs;
            r_s1_rt    <= rt;
            r_s1_imm   <= imm;
        end else if (w_s1_move) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Stage 2 register: capture result/flags on entry, hold while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_result   <= '0;
            r_z        <= 1'b0;
            r_n        <= 1'b0;
            r_v        <= 1'b0;
        end else if (w_s1_move) begin
            r_s2_valid <= 1'b1;
            r_result   <= w_res;
            if (w_upd_z) begin
                r_z <= (w_res == '0);
            end
            if (w_upd_nv) begin
                r_n <= w_res[WIDTH-1];
                r_v <= w_ovf;
            end
        end else if (out_ready) begin
            r_s2_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_pipe
//  Description : Self-checking bench for alu_pipe (WIDTH=16, LANE_W=4).
//                Table-driven vectors feed a scoreboard queue; a monitor pops
//                and compares on every retire. Hand sequences cover latency,
//                back-pressure and reset with operations in flight.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_pipe;
    import alu_pkg::*;

    localparam int WIDTH  = 16;
    localparam int LANE_W = 4;

    typedef struct packed {
        logic [15:0] res;
        logic        z;
        logic        n;
        logic        v;
    } exp_t;

    typedef struct packed {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [7:0]  im;
        exp_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  opcode = '0;
    logic [15:0] rs = '0;
    logic [15:0] rt = '0;
    logic [7:0]  imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] result;
    logic        z;
    logic        n;
    logic        v;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   retired = 0;
    bit   saw_stall = 1'b0;
    bit   prev_stall = 1'b0;
    logic [15:0] prev_res = '0;
    exp_t sb[$];
    exp_t mon_e;
    vec_t tbl[24];
    int   ac[8];
    int   dummy;

    alu_pipe #(
        .WIDTH  (WIDTH),
        .LANE_W (LANE_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .rs        (rs),
        .rt        (rt),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .z         (z),
        .n         (n),
        .v         (v)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
        end
    endtask

    function automatic exp_t mk_exp(input logic [15:0] r, input logic zz, nn, vv);
        exp_t e;
        e.res = r; e.z = zz; e.n = nn; e.v = vv;
        return e;
    endfunction

    function automatic vec_t mkv(input logic [3:0] op, input logic [15:0] a, b,
                                 input logic [7:0] im, input logic [15:0] r,
                                 input logic zz, nn, vv);
        vec_t t;
        t.op = op; t.a = a; t.b = b; t.im = im; t.e = mk_exp(r, zz, nn, vv);
        return t;
    endfunction

    // Independent saturating-add reference using integer clamping
    function automatic exp_t ref_add(input logic [15:0] a, b);
        int   s;
        exp_t e;
        s   = int'($signed(a)) + int'($signed(b));
        e.v = 1'b0;
        if (s > 32767) begin
            s = 32767; e.v = 1'b1;
        end else if (s < -32768) begin
            s = -32768; e.v = 1'b1;
        end
        e.res = s[15:0];
        e.z   = (e.res == 16'h0000);
        e.n   = e.res[15];
        return e;
    endfunction

    // Present one operation, push its expectation on acceptance
    task automatic send(input logic [3:0] op, input logic [15:0] a, b,
                        input logic [7:0] im, input exp_t e, output int acc);
        int k;
        in_valid = 1'b1; opcode = op; rs = a; rt = b; imm = im;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("accept_within_bound", {31'd0, in_ready}, 32'd1);
        if (in_ready) sb.push_back(e);
        @(posedge clk);
        #1;
        acc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("scoreboard_drained", sb.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Retire monitor: scoreboard compare, stall stability, in_ready rule
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk("held_result", {15'd0, out_valid, result}, {15'd0, 1'b1, prev_res});
            if (!in_ready) begin
                saw_stall = 1'b1;
                chk("in_ready_low_only_when_blocked", {30'd0, out_valid, out_ready}, 32'd2);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", {13'd0, result, z, n, v}, 32'hFFFF_FFFF);
                end else begin
                    mon_e = sb.pop_front();
                    chk("retire_result_flags", {13'd0, result, z, n, v}, {13'd0, mon_e});
                    retired++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_res   = result;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = mkv(c_OP_SUB,    16'h0005, 16'h0005, 8'h00, 16'h0000, 1, 0, 0);
        tbl[1]  = mkv(c_OP_XOR,    16'h00F0, 16'h000F, 8'h00, 16'h00FF, 0, 0, 0);
        tbl[2]  = mkv(c_OP_PADDSB, 16'h7F18, 16'h1108, 8'h00, 16'h7018, 0, 0, 0);
        tbl[3]  = mkv(c_OP_SUB,    16'h8000, 16'h0001, 8'h00, 16'h8000, 0, 1, 1);
        tbl[4]  = mkv(c_OP_XOR,    16'h1234, 16'h1234, 8'h00, 16'h0000, 1, 1, 1);
        tbl[5]  = mkv(c_OP_PADDSB, 16'h7F18, 16'h1108, 8'h00, 16'h7018, 1, 1, 1);
        tbl[6]  = mkv(c_OP_RED,    16'h0102, 16'h0304, 8'h00, 16'h000A, 1, 1, 1);
        tbl[7]  = mkv(c_OP_SRA,    16'h8000, 16'h0000, 8'h03, 16'hF000, 0, 1, 1);
        tbl[8]  = mkv(c_OP_ROR,    16'h0001, 16'h0000, 8'h01, 16'h8000, 0, 1, 1);
        tbl[9]  = mkv(c_OP_LHB,    16'h1234, 16'h0000, 8'hAB, 16'hAB34, 0, 1, 1);
        tbl[10] = mkv(c_OP_LLB,    16'h1234, 16'h0000, 8'hCD, 16'h12CD, 0, 1, 1);
        tbl[11] = mkv(c_OP_SLL,    16'h0001, 16'h0000, 8'h13, 16'h0008, 0, 1, 1);
        tbl[12] = mkv(c_OP_SLL,    16'h8000, 16'h0000, 8'h01, 16'h0000, 1, 1, 1);
        tbl[13] = mkv(c_OP_LW,     16'hFFFF, 16'h0002, 8'h00, 16'h0001, 1, 1, 1);
        tbl[14] = mkv(c_OP_SW,     16'h7FFF, 16'h0001, 8'h00, 16'h8000, 1, 1, 1);
        tbl[15] = mkv(4'b1100,     16'hFFFF, 16'hFFFF, 8'hFF, 16'h0000, 1, 1, 1);
        tbl[16] = mkv(4'b1111,     16'h1234, 16'h5678, 8'h9A, 16'h0000, 1, 1, 1);
        tbl[17] = mkv(c_OP_ADD,    16'h8000, 16'hFFFF, 8'h00, 16'h8000, 0, 1, 1);
        tbl[18] = mkv(c_OP_ADD,    16'h0003, 16'hFFFD, 8'h00, 16'h0000, 1, 0, 0);
        tbl[19] = mkv(c_OP_RED,    16'hFF80, 16'h8080, 8'h00, 16'hFE7F, 1, 0, 0);
        tbl[20] = mkv(c_OP_ROR,    16'h1234, 16'h0000, 8'h14, 16'h4123, 0, 0, 0);
        tbl[21] = mkv(c_OP_SUB,    16'h0003, 16'h0005, 8'h00, 16'hFFFE, 0, 1, 0);
        tbl[22] = mkv(c_OP_PADDSB, 16'h8888, 16'h8888, 8'h00, 16'h8888, 0, 1, 0);
        tbl[23] = mkv(c_OP_SRA,    16'h4000, 16'h0000, 8'hF2, 16'h1000, 0, 1, 0);

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_result", {16'd0, result}, 32'd0);
        chk("reset_flags", {29'd0, z, n, v}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Saturating ADD with two-cycle latency
        send(c_OP_ADD, 16'h7FFF, 16'h0001, 8'h00, mk_exp(16'h7FFF, 0, 0, 1), dummy);
        @(negedge clk);
        chk("latency_not_early", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("latency_two_cycles", {31'd0, out_valid}, 32'd1);
        drain();

        // Table vectors, back-to-back
        for (int i = 0; i < 24; i++)
            send(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].im, tbl[i].e, dummy);
        drain();

        // Stream of 8 ADDs with out_ready low for 3 cycles mid-stream
        retired   = 0;
        saw_stall = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    logic [15:0] a, b;
                    a = 16'($urandom);
                    b = 16'($urandom);
                    send(c_OP_ADD, a, b, 8'h00, ref_add(a, b), ac[i]);
                end
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        chk("stream_retired_count", retired, 32'd8);
        chk("stream_saw_in_ready_low", {31'd0, saw_stall}, 32'd1);
        chk("stream_accept_span", ac[7] - ac[0], 32'd10);

        // Reset pulse with two operations in flight
        send(c_OP_ADD, 16'h7FFF, 16'h0001, 8'h00, mk_exp(16'h7FFF, 0, 0, 1), dummy);
        send(c_OP_SUB, 16'h8000, 16'h0001, 8'h00, mk_exp(16'h8000, 0, 1, 1), dummy);
        out_ready = 1'b0;
        rst       = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rst_flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_flush_result", {16'd0, result}, 32'd0);
        chk("rst_flush_flags", {29'd0, z, n, v}, 32'd0);
        chk("rst_flush_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        retired = 0;
        send(c_OP_ADD, 16'h0001, 16'h0001, 8'h00, mk_exp(16'h0002, 0, 0, 0), dummy);
        @(negedge clk);
        chk("post_rst_not_early", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("post_rst_latency", {31'd0, out_valid}, 32'd1);
        drain();
        chk("post_rst_single_retire", retired, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 16, datapath width; SHALL be a multiple of 8 and at least 16.
REQ-002 Parameter LANE_W, default 4, PADDSB sub-word lane width; SHALL divide WIDTH.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  an operation is presented.
REQ-006 in_ready  output  1  the block accepts an operation this cycle.
REQ-007 opcode  input  4  operation select, encodings per REQ-013.
REQ-008 rs  input  WIDTH  first operand.
REQ-009 rt  input  WIDTH  second operand.
REQ-010 imm  input  8  immediate for shift amount, LLB and LHB.
REQ-011 out_valid / out_ready  output / input  1 each  result handshake.
REQ-012 result  output  WIDTH; z, n, v  output  1 each  registered flag state.

Function
REQ-013 Opcodes SHALL map as follows:
- 0000 ADD, saturating.
- 0001 SUB, saturating (rs-rt).
- 0010 XOR.
- 0011 RED: signed sum of all bytes of rs and rt, sign-extended to WIDTH.
- 0100 SLL, 0101 SRA, 0110 ROR: operand rs, amount imm[log2(WIDTH)-1:0].
- 0111 PADDSB: per-lane saturating signed add.
- 1000/1001 LW/SW: wrapping rs+rt (address).
- 1010 LLB: rs with bits [7:0] replaced by imm.
- 1011 LHB: rs with bits [15:8] replaced by imm.
- 1100-1111: result 0.
REQ-014 Saturation SHALL clamp positive overflow to 0111..1 and negative overflow to 1000..0, at WIDTH for ADD/SUB and at LANE_W for each PADDSB lane.
REQ-015 Pipeline SHALL be two register stages: operand capture, then result/flag register; latency SHALL be exactly 2 cycles with no stall.
REQ-016 An operation SHALL transfer on in_valid&&in_ready; a result SHALL retire on out_valid&&out_ready.
REQ-017 in_ready SHALL be low only when both stages are full and out_ready is low; a full pipeline with out_ready high SHALL accept one operation per cycle.
REQ-018 While out_valid is high and out_ready is low, result SHALL hold stable and no operation SHALL be dropped, duplicated or reordered.
REQ-019 z, n, v SHALL update in the cycle an operation enters the result stage:
- ADD/SUB: z=(result==0), n=result[WIDTH-1], v=saturation occurred, with z and n taken on the saturated value.
- XOR/SLL/SRA/ROR: z only.
- All other opcodes: flags unchanged.
REQ-020 Unused opcodes 1100-1111 SHALL flow through the pipeline like any other operation and produce result 0.

Reset
REQ-021 While rst is high, both stages SHALL empty; out_valid, result, z, n and v SHALL read 0 on the following cycle, and in_ready SHALL read 1.
REQ-022 Reset asserted with operations in flight SHALL discard them; none of them SHALL ever appear at the output.

Structure
REQ-023 Opcode localparams and saturation-limit constants SHALL reside in shared package alu_pkg.
REQ-024 The shift/rotate datapath SHALL be the sub-module alu_shift_unit, parametrised by WIDTH and purely combinational; all other logic SHALL reside in alu_pipe.

Verification
REQ-025 ADD rs=0x7FFF, rt=0x0001 -> result 0x7FFF two cycles later, v=1, n=0, z=0.
REQ-026 Flag retention:
- SUB 0x0005-0x0005 -> result 0x0000, z=1.
- Then XOR 0x00F0^0x000F -> result 0x00FF, z=0, n and v held.
- Then PADDSB -> all three flags held.
REQ-027 Datapath values, LANE_W=4:
- PADDSB 0x7F18+0x1108 -> 0x7018.
- RED 0x0102,0x0304 -> 0x000A.
- SRA 0x8000 imm=3 -> 0xF000.
- ROR 0x0001 imm=1 -> 0x8000.
- LHB rs=0x1234 imm=0xAB -> 0xAB34.
REQ-028 Back-to-back stream of 8 ADDs with out_ready low for 3 cycles mid-stream -> in_ready drops while both stages are full; all 8 results retire in order, none lost.
REQ-029 rst pulsed for 1 cycle with two operations in flight -> next cycle out_valid=0, z=n=v=0, in_ready=1; the next accepted operation emerges after 2 cycles.
